// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns engine with valid/ready handshakes on both sides.
// Define MIXCOL_INV_EN to add the 'inv' port and InvMixColumns mode.
module mix_columns_seq #(
    parameter int NUM_COLS       = 4,
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
`ifdef MIXCOL_INV_EN
    input  logic         inv,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int CNT_W = $clog2(NUM_COLS) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [127:0]       work, work_next;
    logic               last_step;
`ifdef MIXCOL_INV_EN
    logic               mode, mode_next;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        // 3*x is expanded as xtime(x) ^ x
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

`ifdef MIXCOL_INV_EN
    function automatic logic [7:0] mul_e(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

    function automatic logic [7:0] mul_b(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] mul_d(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] mul_9(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [31:0] mix_inv(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {mul_e(a0) ^ mul_b(a1) ^ mul_d(a2) ^ mul_9(a3),
                mul_9(a0) ^ mul_e(a1) ^ mul_b(a2) ^ mul_d(a3),
                mul_d(a0) ^ mul_9(a1) ^ mul_e(a2) ^ mul_b(a3),
                mul_b(a0) ^ mul_d(a1) ^ mul_9(a2) ^ mul_e(a3)};
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c, input logic m);
        return m ? mix_inv(c) : mix_fwd(c);
    endfunction
`else
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        return mix_fwd(c);
    endfunction
`endif

    assign last_step = (cnt + CNT_W'(COLS_PER_CYCLE)) == CNT_W'(NUM_COLS);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = work;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
`ifdef MIXCOL_INV_EN
            mode  <= 1'b0;
`endif
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            work  <= work_next;
`ifdef MIXCOL_INV_EN
            mode  <= mode_next;
`endif
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        work_next  = work;
`ifdef MIXCOL_INV_EN
        mode_next  = mode;
`endif
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    work_next  = in_data;
                    cnt_next   = '0;
`ifdef MIXCOL_INV_EN
                    mode_next  = inv;
`endif
                    state_next = BUSY;
                end
            end
            BUSY: begin
                // Columns are rewritten in place; untouched columns keep their input value
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
`ifdef MIXCOL_INV_EN
                    work_next[127 - 32*(int'(cnt) + k) -: 32] =
                        mix_col(work[127 - 32*(int'(cnt) + k) -: 32], mode);
`else
                    work_next[127 - 32*(int'(cnt) + k) -: 32] =
                        mix_col(work[127 - 32*(int'(cnt) + k) -: 32]);
`endif
                end
                cnt_next = cnt + CNT_W'(COLS_PER_CYCLE);
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Scoreboard bench for mix_columns_seq; define MIXCOL_INV_EN to also exercise inverse mode.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
`ifdef MIXCOL_INV_EN
    logic         inv;
`endif

    int           cyc = 0;
    int           total = 0;
    int           passed = 0;
    logic [127:0] sb[$];
    int           in_hs[$];

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] KNOWN_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] KNOWN_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

    mix_columns_seq dut (
        .clk       (clk),
        .reset     (reset),
`ifdef MIXCOL_INV_EN
        .inv       (inv),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Generic shift-and-add GF(2^8) multiply, independent of the xtime chains in the design
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model_mix(input logic [127:0] s, input bit inv_mode);
        logic [7:0]   coef[4];
        logic [7:0]   a[4];
        logic [7:0]   r;
        logic [127:0] o;
        if (inv_mode) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else          coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
            for (int i = 0; i < 4; i++) begin
                r = 8'h00;
                for (int j = 0; j < 4; j++) r = r ^ gmul(coef[(j - i + 4) % 4], a[j]);
                o[127 - 32*c - 8*i -: 8] = r;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Starts and ends on a falling edge; pushes the expectation when the handshake edge passes
    task automatic send(input logic [127:0] d, input logic [127:0] exp, input bit keep, output bit to);
        in_data  = d;
        in_valid = 1'b1;
        to = 1'b1;
        for (int i = 0; i < 40 && to; i++) begin
            if (in_ready) begin
                @(posedge clk);
                @(negedge clk);
                sb.push_back(exp);
                in_hs.push_back(cyc);
                to = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        if (!keep || to) in_valid = 1'b0;
    endtask

    task automatic wait_output(input int budget, output logic [127:0] data,
                               output int valid_cyc, output int hs_cyc, output bit to);
        to = 1'b1;
        valid_cyc = -1;
        hs_cyc = -1;
        data = '0;
        for (int i = 0; i < budget && to; i++) begin
            if (out_valid) begin
                if (valid_cyc < 0) valid_cyc = cyc;
                if (out_ready) begin
                    data = out_data;
                    @(posedge clk);
                    @(negedge clk);
                    hs_cyc = cyc;
                    to = 1'b0;
                end else begin
                    @(negedge clk);
                end
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
`ifdef MIXCOL_INV_EN
        inv = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
        total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (out_data !== 128'h0) $display("[TB] FAIL reset_out_data: got %h want 0", out_data); else passed++;
        reset = 1'b0;
        @(negedge clk);
        total++; if ({busy, in_ready} !== 2'b01) $display("[TB] FAIL idle_after_reset: got busy,in_ready=%b want 01", {busy, in_ready}); else passed++;
    endtask

    task automatic test_fips();
        bit to;
        logic [127:0] d, exp;
        int vc, oh, ih;
        out_ready = 1'b1;
        send(FIPS_IN, FIPS_OUT, 1'b0, to);
        total++; if (to) $display("[TB] FAIL fips_in_handshake: got timeout want accept"); else passed++;
        total++; if ({busy, in_ready} !== 2'b10) $display("[TB] FAIL fips_busy: got busy,in_ready=%b want 10", {busy, in_ready}); else passed++;
        wait_output(20, d, vc, oh, to);
        total++;
        if (to || sb.size() == 0) begin
            $display("[TB] FAIL fips_output: got timeout want result");
            sb.delete(); in_hs.delete();
        end else begin
            passed++;
            exp = sb.pop_front();
            ih = in_hs.pop_front();
            total++; if (d !== exp) $display("[TB] FAIL fips_data: got %h want %h", d, exp); else passed++;
            total++; if (vc - ih != 4) $display("[TB] FAIL fips_latency: got %0d want 4", vc - ih); else passed++;
            total++; if (oh - ih != 5) $display("[TB] FAIL fips_out_handshake: got %0d want 5", oh - ih); else passed++;
        end
    endtask

    task automatic test_known_columns();
        bit to;
        logic [127:0] d, exp;
        int vc, oh, ih;
        out_ready = 1'b1;
        send(KNOWN_IN, KNOWN_OUT, 1'b0, to);
        wait_output(20, d, vc, oh, to);
        total++;
        if (to || sb.size() == 0) begin
            $display("[TB] FAIL known_output: got timeout want result");
            sb.delete(); in_hs.delete();
        end else begin
            passed++;
            exp = sb.pop_front();
            ih = in_hs.pop_front();
            total++; if (d !== exp) $display("[TB] FAIL known_data: got %h want %h", d, exp); else passed++;
        end
    endtask

    task automatic test_backpressure();
        bit to, got;
        logic [127:0] s, exp;
        s = rand_state();
        out_ready = 1'b0;
        send(s, model_mix(s, 1'b0), 1'b0, to);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (out_valid) got = 1'b1;
            else @(negedge clk);
        end
        total++;
        if (!got || sb.size() == 0) begin
            $display("[TB] FAIL bp_out_valid: got timeout want out_valid");
            sb.delete(); in_hs.delete();
        end else begin
            passed++;
            exp = sb.pop_front();
            void'(in_hs.pop_front());
            for (int i = 0; i < 10; i++) begin
                total++; if (out_valid !== 1'b1) $display("[TB] FAIL bp_hold_valid: got %b want 1", out_valid); else passed++;
                total++; if (out_data !== exp) $display("[TB] FAIL bp_hold_data: got %h want %h", out_data, exp); else passed++;
                total++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready: got %b want 0", in_ready); else passed++;
                if (i == 3) begin
                    in_valid = 1'b1;
                    in_data = ~s;
                end
                if (i == 4) in_valid = 1'b0;
                @(negedge clk);
            end
            out_ready = 1'b1;
            @(negedge clk);
            total++; if ({in_ready, out_valid} !== 2'b10) $display("[TB] FAIL bp_release: got in_ready,out_valid=%b want 10", {in_ready, out_valid}); else passed++;
            @(negedge clk);
            @(negedge clk);
            total++; if (busy !== 1'b0) $display("[TB] FAIL bp_no_capture_busy: got %b want 0", busy); else passed++;
            total++; if (out_data !== exp) $display("[TB] FAIL bp_no_capture_data: got %h want %h", out_data, exp); else passed++;
        end
    endtask

    task automatic test_reset_mid_op();
        bit to;
        logic [127:0] s, d, exp;
        int vc, oh;
        s = rand_state();
        out_ready = 1'b1;
        send(s, model_mix(s, 1'b0), 1'b0, to);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL midrst_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("[TB] FAIL midrst_in_ready: got %b want 1", in_ready); else passed++;
        total++; if (out_data !== 128'h0) $display("[TB] FAIL midrst_out_data: got %h want 0", out_data); else passed++;
        total++; if (busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %b want 0", busy); else passed++;
        sb.delete();
        in_hs.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        s = rand_state();
        send(s, model_mix(s, 1'b0), 1'b0, to);
        wait_output(20, d, vc, oh, to);
        total++;
        if (to || sb.size() == 0) begin
            $display("[TB] FAIL midrst_next_output: got timeout want result");
            sb.delete(); in_hs.delete();
        end else begin
            passed++;
            exp = sb.pop_front();
            void'(in_hs.pop_front());
            total++; if (d !== exp) $display("[TB] FAIL midrst_next_data: got %h want %h", d, exp); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] states[3];
        for (int k = 0; k < 3; k++) states[k] = rand_state();
        out_ready = 1'b1;
        fork
            begin
                bit to;
                for (int k = 0; k < 3; k++) begin
                    send(states[k], model_mix(states[k], 1'b0), k < 2, to);
                    total++; if (to) $display("[TB] FAIL b2b_in_handshake: got timeout want accept (state %0d)", k); else passed++;
                end
                in_valid = 1'b0;
            end
            begin
                bit to;
                logic [127:0] d, exp;
                int vc, oh, ih;
                for (int k = 0; k < 3; k++) begin
                    wait_output(40, d, vc, oh, to);
                    total++;
                    if (to || sb.size() == 0) begin
                        $display("[TB] FAIL b2b_output: got timeout want result %0d", k);
                    end else begin
                        passed++;
                        exp = sb.pop_front();
                        ih = in_hs.pop_front();
                        total++; if (d !== exp) $display("[TB] FAIL b2b_data: got %h want %h", d, exp); else passed++;
                        total++; if (oh - ih != 5) $display("[TB] FAIL b2b_gap: got %0d want 5", oh - ih); else passed++;
                    end
                end
            end
        join
        sb.delete();
        in_hs.delete();
    endtask

`ifdef MIXCOL_INV_EN
    task automatic test_inverse();
        bit to;
        logic [127:0] d, exp, s;
        int vc, oh;
        out_ready = 1'b1;
        inv = 1'b1;
        send(FIPS_OUT, FIPS_IN, 1'b0, to);
        @(negedge clk);
        inv = 1'b0;
        wait_output(20, d, vc, oh, to);
        total++;
        if (to || sb.size() == 0) begin
            $display("[TB] FAIL inv_output: got timeout want result");
            sb.delete(); in_hs.delete();
        end else begin
            passed++;
            exp = sb.pop_front();
            void'(in_hs.pop_front());
            total++; if (d !== exp) $display("[TB] FAIL inv_data: got %h want %h", d, exp); else passed++;
        end
        s = rand_state();
        inv = 1'b1;
        send(s, model_mix(s, 1'b1), 1'b0, to);
        inv = 1'b0;
        wait_output(20, d, vc, oh, to);
        total++;
        if (to || sb.size() == 0) begin
            $display("[TB] FAIL inv_rand_output: got timeout want result");
            sb.delete(); in_hs.delete();
        end else begin
            passed++;
            exp = sb.pop_front();
            void'(in_hs.pop_front());
            total++; if (d !== exp) $display("[TB] FAIL inv_rand_data: got %h want %h", d, exp); else passed++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fips();
        test_known_columns();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
`ifdef MIXCOL_INV_EN
        test_inverse();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
